// File: rtl/sid_pkg.sv
// Shared SID audio-path definitions: sample width, midscale, DAC state
// encoding and the volume-scaling arithmetic used when a sample is loaded.
package sid_pkg;

  localparam int SID_SAMPLE_W = 15;
  localparam logic [SID_SAMPLE_W-1:0] SID_MIDSCALE = 15'd16384;
  localparam logic [SID_SAMPLE_W-1:0] SID_FULLSCALE = 15'd32767;

  typedef enum logic [1:0] {
    SID_WAIT = 2'd0,
    SID_LOAD = 2'd1,
    SID_RUN  = 2'd2,
    SID_RAMP = 2'd3
  } sid_state_e;

  // Plain-vector aliases of the enum, used for the state register and debug port.
  localparam logic [1:0] ST_WAIT = SID_WAIT;
  localparam logic [1:0] ST_LOAD = SID_LOAD;
  localparam logic [1:0] ST_RUN  = SID_RUN;
  localparam logic [1:0] ST_RAMP = SID_RAMP;

  // Re-centre around midscale, apply vol/16 with floor rounding, re-offset and clamp.
  function automatic logic [SID_SAMPLE_W-1:0] sid_scale(
    input logic [SID_SAMPLE_W-1:0] sample,
    input logic [3:0]              vol
  );
    logic signed [15:0] centred;
    logic signed [20:0] prod;
    logic signed [16:0] scaled;
    logic signed [17:0] sum;
    centred = $signed({1'b0, sample}) - 16'sd16384;
    prod    = centred * $signed({1'b0, vol});
    scaled  = prod[20:4];
    sum     = {scaled[16], scaled} + 18'sd16384;
    if (sum < 18'sd0) begin
      sid_scale = '0;
    end else if (sum > 18'sd32767) begin
      sid_scale = SID_FULLSCALE;
    end else begin
      sid_scale = sum[SID_SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sid_dac_if.sv
// Sample/volume input bundle and bitstream/debug outputs of the SID DAC.
interface sid_dac_if;
  import sid_pkg::*;

  // Handshake: a sample is transferred on any clk edge where clk_enable and
  // sample_ready are both high; the DAC never stalls the producer, and
  // sample_taken acknowledges the transfer one clk later.
  logic                    clk_enable;
  logic [SID_SAMPLE_W-1:0] sample_in;
  logic                    sample_ready;
  logic [3:0]              vol;
  logic                    dac_out;
  logic [SID_SAMPLE_W-1:0] level_out;
  logic                    sample_taken;
  logic [1:0]              fsm_state;

  modport master (
    output clk_enable, sample_in, sample_ready, vol,
    input  dac_out, level_out, sample_taken, fsm_state
  );

  modport slave (
    input  clk_enable, sample_in, sample_ready, vol,
    output dac_out, level_out, sample_taken, fsm_state
  );

endinterface

// File: rtl/sid_sd_mod.sv
// First-order delta-sigma modulator: the 15-bit accumulator overflow is the bitstream.
module sid_sd_mod
  import sid_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SID_SAMPLE_W-1:0] level,
  output logic                    bit_out
);

  logic [SID_SAMPLE_W-1:0] acc;
  logic [SID_SAMPLE_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, level};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      bit_out <= 1'b0;
    end else begin
      acc     <= sum[SID_SAMPLE_W-1:0];
      bit_out <= sum[SID_SAMPLE_W];
    end
  end

endmodule

// File: rtl/sid_dac.sv
// SID output DAC: captures filter samples, applies master volume, drives a delta-sigma bitstream.
// Define SID_DAC_INTERP_EN to glide level_out to each new target over 8 SID ticks.
module sid_dac
  import sid_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  sid_dac_if.slave bus
);

  logic [1:0]              state;
  logic [SID_SAMPLE_W-1:0] latched;
  logic [SID_SAMPLE_W-1:0] target_c;
  logic [SID_SAMPLE_W-1:0] target_q;
  logic [SID_SAMPLE_W-1:0] level;
  logic                    taken;
  logic                    capture;
  logic                    dac_bit;

  assign capture  = bus.clk_enable && bus.sample_ready;
  // vol only matters here, so a volume change between captures leaves level alone.
  assign target_c = sid_scale(latched, bus.vol);

`ifdef SID_DAC_INTERP_EN
  logic signed [15:0]      step;
  logic [2:0]              ramp_cnt;
  logic signed [15:0]      diff;
  logic [16:0]             ramp_sum;
  logic [SID_SAMPLE_W-1:0] ramp_next;

  assign diff     = $signed({1'b0, target_c}) - $signed({1'b0, level});
  assign ramp_sum = {2'b00, level} + {step[15], step};

  // Floor rounding of step can overshoot by a few LSBs; keep the ramp in range.
  always_comb begin
    ramp_next = ramp_sum[SID_SAMPLE_W-1:0];
    if (ramp_sum[16]) begin
      ramp_next = '0;
    end else if (ramp_sum[15]) begin
      ramp_next = SID_FULLSCALE;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_WAIT;
      latched  <= SID_MIDSCALE;
      target_q <= SID_MIDSCALE;
      level    <= SID_MIDSCALE;
      taken    <= 1'b0;
`ifdef SID_DAC_INTERP_EN
      step     <= '0;
      ramp_cnt <= '0;
`endif
    end else begin
      taken <= capture;
      if (capture) begin
        // A capture in any state restarts from LOAD; level_out holds meanwhile.
        latched <= bus.sample_in;
        state   <= ST_LOAD;
      end else begin
        case (state)
          ST_LOAD: begin
            target_q <= target_c;
`ifdef SID_DAC_INTERP_EN
            step     <= diff >>> 3;
            ramp_cnt <= '0;
            state    <= ST_RAMP;
`else
            state    <= ST_RUN;
`endif
          end
`ifdef SID_DAC_INTERP_EN
          ST_RAMP: begin
            if (bus.clk_enable) begin
              if (ramp_cnt == 3'd7) begin
                level <= target_q;
                state <= ST_RUN;
              end else begin
                level    <= ramp_next;
                ramp_cnt <= ramp_cnt + 3'd1;
              end
            end
          end
`endif
          default: ;
        endcase
      end
`ifndef SID_DAC_INTERP_EN
      // Second stage of the two-clk load pipeline.
      if (state == ST_RUN) begin
        level <= target_q;
      end
`endif
    end
  end

  sid_sd_mod u_mod (
    .clk     (clk),
    .rst     (rst),
    .level   (level),
    .bit_out (dac_bit)
  );

  assign bus.dac_out      = dac_bit;
  assign bus.level_out    = level;
  assign bus.sample_taken = taken;
  assign bus.fsm_state    = state;

endmodule

// File: tb/tb_sid_dac.sv
// Self-checking bench for sid_dac: vector table, scoreboard queue, hand-written reset/ramp sequences.
`timescale 1ns/1ps
module tb_sid_dac;
  import sid_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sid_dac_if bus();
  sid_dac dut (.clk(clk), .rst(rst), .bus(bus));

  // Stand-alone modulators for the rail levels the volume path can never reach.
  logic [14:0] m0_level, m1_level;
  logic        m0_bit, m1_bit;
  sid_sd_mod m0 (.clk(clk), .rst(rst), .level(m0_level), .bit_out(m0_bit));
  sid_sd_mod m1 (.clk(clk), .rst(rst), .level(m1_level), .bit_out(m1_bit));

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];

  typedef struct {
    logic [14:0] sample;
    logic [3:0]  vol;
    logic [14:0] exp_level;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_target(input int s, input int v);
    int p, q;
    p = (s - 16384) * v;
    q = (p >= 0) ? (p / 16) : -((-p + 15) / 16);
    q = q + 16384;
    if (q < 0) q = 0;
    if (q > 32767) q = 32767;
    return q;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sample_ready = 1'b0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Drive one capture, expect the ack pulse, then compare the settled level.
  task automatic do_capture(input logic [14:0] s, input logic [3:0] v,
                            input logic [14:0] exp, input string name);
    logic [14:0] e;
    int          n;
    exp_q.push_back(exp);
    bus.sample_in    = s;
    bus.vol          = v;
    bus.sample_ready = 1'b1;
    @(negedge clk);
    bus.sample_ready = 1'b0;
    check({name, " taken"}, 32'(bus.sample_taken), 32'd1);
    check({name, " load"}, 32'(bus.fsm_state), 32'(ST_LOAD));
    @(negedge clk);
    check({name, " taken_clr"}, 32'(bus.sample_taken), 32'd0);
    n = 0;
    while (bus.fsm_state !== ST_RUN && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " run"}, 32'(bus.fsm_state), 32'(ST_RUN));
    @(negedge clk);
    e = exp_q.pop_front();
    check({name, " level"}, 32'(bus.level_out), 32'(e));
  endtask

  initial begin
    int ones, m0_ones, m1_ones, taken_seen;
    logic [14:0] s, e;
    logic [3:0]  v;

    vecs[0] = '{15'd32767, 4'd15, 15'd31743};
    vecs[1] = '{15'd0,     4'd8,  15'd8192};
    vecs[2] = '{15'd12345, 4'd0,  15'd16384};
    vecs[3] = '{15'd0,     4'd15, 15'd1024};
    vecs[4] = '{15'd32767, 4'd1,  15'd17407};
    vecs[5] = '{15'd16384, 4'd9,  15'd16384};
    vecs[6] = '{15'd20000, 4'd7,  15'd17966};
    vecs[7] = '{15'd100,   4'd3,  15'd13330};
    vecs[8] = '{15'd0,     4'd1,  15'd15360};

    rst = 1'b1;
    bus.clk_enable   = 1'b1;
    bus.sample_ready = 1'b0;
    bus.sample_in    = '0;
    bus.vol          = 4'd15;
    m0_level = 15'd0;
    m1_level = 15'd32767;
    idle(3);
    check("rst level", 32'(bus.level_out), 32'd16384);
    check("rst dac", 32'(bus.dac_out), 32'd0);
    check("rst taken", 32'(bus.sample_taken), 32'd0);
    check("rst state", 32'(bus.fsm_state), 32'(ST_WAIT));
    rst = 1'b0;

    // Idle: midscale level, exact 50% bitstream, no ack.
    ones = 0;
    taken_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ones += int'(bus.dac_out);
      taken_seen += int'(bus.sample_taken);
    end
    check("idle ones", 32'(ones), 32'd500);
    check("idle taken", 32'(taken_seen), 32'd0);
    check("idle level", 32'(bus.level_out), 32'd16384);
    check("idle state", 32'(bus.fsm_state), 32'(ST_WAIT));

    for (int i = 0; i < 9; i++) begin
      do_capture(vecs[i].sample, vecs[i].vol, vecs[i].exp_level, $sformatf("vec%0d", i));
    end

    // Volume change with no capture must not move level_out.
    bus.vol = 4'd3;
    idle(10);
    check("vol_hold", 32'(bus.level_out), 32'd15360);

    for (int i = 0; i < 6; i++) begin
      s = 15'($urandom_range(0, 32767));
      v = 4'($urandom_range(0, 15));
      do_capture(s, v, 15'(ref_target(int'(s), int'(v))), $sformatf("rnd%0d", i));
    end

    // Back-to-back captures: the second overwrites the first during LOAD.
    exp_q.push_back(15'd8192);
    bus.sample_in = 15'd32767; bus.vol = 4'd15; bus.sample_ready = 1'b1;
    @(negedge clk);
    bus.sample_in = 15'd0; bus.vol = 4'd8;
    check("dbl taken1", 32'(bus.sample_taken), 32'd1);
    @(negedge clk);
    bus.sample_ready = 1'b0;
    check("dbl taken2", 32'(bus.sample_taken), 32'd1);
    check("dbl load", 32'(bus.fsm_state), 32'(ST_LOAD));
    for (int i = 0; i < 20 && bus.fsm_state !== ST_RUN; i++) @(negedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check("dbl level", 32'(bus.level_out), 32'(e));

    // Capture coincident with reset: reset wins.
    rst = 1'b1; bus.sample_in = 15'd0; bus.vol = 4'd15; bus.sample_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.sample_ready = 1'b0;
    check("rstcap taken", 32'(bus.sample_taken), 32'd0);
    check("rstcap state", 32'(bus.fsm_state), 32'(ST_WAIT));
    idle(5);
    check("rstcap level", 32'(bus.level_out), 32'd16384);

    // Reset mid-LOAD abandons the load.
    bus.sample_ready = 1'b1;
    @(negedge clk);
    bus.sample_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(12);
    check("rstload level", 32'(bus.level_out), 32'd16384);
    check("rstload state", 32'(bus.fsm_state), 32'(ST_WAIT));

`ifdef SID_DAC_INTERP_EN
    // Full ramp from midscale down to 1024 in steps of -1920.
    do_reset();
    bus.sample_in = 15'd0; bus.vol = 4'd15; bus.sample_ready = 1'b1;
    @(negedge clk);
    bus.sample_ready = 1'b0;
    @(negedge clk);
    check("ramp enter", 32'(bus.fsm_state), 32'(ST_RAMP));
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("ramp step%0d", k), 32'(bus.level_out), 32'(16384 - 1920 * k));
    end
    @(negedge clk);
    check("ramp final", 32'(bus.level_out), 32'd1024);
    check("ramp run", 32'(bus.fsm_state), 32'(ST_RUN));

    // Capture after 4 steps restarts from the intermediate level.
    do_reset();
    bus.sample_in = 15'd0; bus.vol = 4'd15; bus.sample_ready = 1'b1;
    @(negedge clk);
    bus.sample_ready = 1'b0;
    idle(5);
    check("reramp mid", 32'(bus.level_out), 32'd8704);
    bus.sample_in = 15'd32767; bus.sample_ready = 1'b1;
    @(negedge clk);
    bus.sample_ready = 1'b0;
    check("reramp hold", 32'(bus.level_out), 32'd8704);
    idle(2);
    check("reramp step1", 32'(bus.level_out), 32'd11583);
    idle(7);
    check("reramp final", 32'(bus.level_out), 32'd31743);
    check("reramp run", 32'(bus.fsm_state), 32'(ST_RUN));
`endif

    // Bitstream density at a loaded level and at both rails.
    do_capture(15'd32767, 4'd15, 15'd31743, "dens");
    ones = 0; m0_ones = 0; m1_ones = 0;
    for (int i = 0; i < 32768; i++) begin
      @(negedge clk);
      ones    += int'(bus.dac_out);
      m0_ones += int'(m0_bit);
      m1_ones += int'(m1_bit);
    end
    check("dens ones", 32'(ones), 32'd31743);
    check("rail0 ones", 32'(m0_ones), 32'd0);
    check("rail1 ones", 32'(m1_ones), 32'd32767);
    check("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
